vga_rx_decode: RTL and testbench

Video sink that decodes the pong core's VGA stream (hsync, vsync, de) back into pixel coordinates and timing measurements. It sits on the far end of the VGA output, either in the bench or on a companion capture path. It recovers x/y per active pixel, measures line and frame lengths against nominal 640x480 timing, and runs a lock state machine that reports whether the incoming stream is stable and standard.

---
 rtl/vga_pkg.sv | 17 +
 rtl/vga_rx_edge.sv | 37 +++
 rtl/vga_rx_decode.sv | 235 +++++++++++++++++++++++
 tb/tb_vga_rx_decode.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and lock FSM state type for the pong video path.
package vga_pkg;

   localparam int unsigned H_ACTIVE    = 640;
   localparam int unsigned V_ACTIVE    = 480;
   localparam int unsigned H_TOTAL     = 800;
   localparam int unsigned V_TOTAL     = 525;
   localparam bit          SYNC_NEG    = 1'b1;
   localparam int unsigned LOCK_FRAMES = 2;

   typedef enum logic [1:0] {
      StSearch,
      StTrack,
      StLocked
   } lock_state_e;

endpackage

// File: rtl/vga_rx_edge.sv
// Input register, polarity normalisation and edge detection for one sync/enable line.
module vga_rx_edge #(
   parameter bit INVERT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic level_d, level_q;
   logic prev_d, prev_q;

   // Normalise to active-high and keep one cycle of history.
   always_comb begin
      level_d = sig_i ^ INVERT;
      prev_d  = level_q;
   end

   // Reset to the inactive level so a stream already asserted shows a leading edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         level_q <= level_d;
         prev_q  <= prev_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = level_q & ~prev_q;
   assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/vga_rx_decode.sv
// VGA stream sink: recovers pixel coordinates, measures line/frame lengths and tracks lock.
module vga_rx_decode #(
   parameter int unsigned H_ACTIVE    = vga_pkg::H_ACTIVE,
   parameter int unsigned V_ACTIVE    = vga_pkg::V_ACTIVE,
   parameter int unsigned H_TOTAL     = vga_pkg::H_TOTAL,
   parameter int unsigned V_TOTAL     = vga_pkg::V_TOTAL,
   parameter bit          SYNC_NEG    = vga_pkg::SYNC_NEG,
   parameter int unsigned LOCK_FRAMES = vga_pkg::LOCK_FRAMES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        de,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        px_valid,
   output logic        line_start,
   output logic        frame_start,
   output logic [10:0] h_meas,
   output logic [9:0]  v_meas,
   output logic        locked,
   output logic        err,
   output logic [7:0]  err_cnt
);

   import vga_pkg::*;

   localparam logic [10:0] HTotal     = 11'(H_TOTAL);
   localparam logic [10:0] HActive    = 11'(H_ACTIVE);
   localparam logic [9:0]  VTotal     = 10'(V_TOTAL);
   localparam logic [9:0]  VActive    = 10'(V_ACTIVE);
   localparam logic [7:0]  LockFrames = 8'(LOCK_FRAMES);
   localparam logic [10:0] HMax       = 11'h7FF;
   localparam logic [9:0]  VMax       = 10'h3FF;

   logic hs_lvl, hs_rise, hs_fall;
   logic vs_lvl, vs_rise, vs_fall;
   logic de_lvl, de_rise, de_fall;

   vga_rx_edge #(.INVERT(SYNC_NEG)) u_hs_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (hsync),
      .level_o(hs_lvl),
      .rise_o (hs_rise),
      .fall_o (hs_fall)
   );

   vga_rx_edge #(.INVERT(SYNC_NEG)) u_vs_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (vsync),
      .level_o(vs_lvl),
      .rise_o (vs_rise),
      .fall_o (vs_fall)
   );

   vga_rx_edge #(.INVERT(1'b0)) u_de_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (de),
      .level_o(de_lvl),
      .rise_o (de_rise),
      .fall_o (de_fall)
   );

   // Sync levels and trailing edges are not needed; only leading edges matter.
   logic unused_sync;
   assign unused_sync = ^{hs_lvl, hs_fall, vs_lvl, vs_fall};

   logic [10:0] h_cnt_d, h_cnt_q, h_meas_d, h_meas_q;
   logic [9:0]  v_cnt_d, v_cnt_q, v_meas_d, v_meas_q;
   logic [9:0]  x_d, x_q, y_d, y_q;
   logic        px_valid_d, px_valid_q;
   logic        line_start_d, line_start_q, frame_start_d, frame_start_q;
   logic        skip_h_d, skip_h_q;
   logic        err_d, err_q;
   logic [7:0]  err_cnt_d, err_cnt_q;
   logic [7:0]  gf_d, gf_q;
   logic        frame_bad_d, frame_bad_q;
   lock_state_e state_d, state_q;

   logic        h_sat_hit, v_sat_hit;
   logic [10:0] run_len;
   logic [9:0]  act_lines;
   logic        mismatch;

   // Line/frame counters, measurements and pixel coordinates.
   always_comb begin
      h_cnt_d       = h_cnt_q;
      h_meas_d      = h_meas_q;
      line_start_d  = 1'b0;
      h_sat_hit     = 1'b0;
      v_cnt_d       = v_cnt_q;
      v_meas_d      = v_meas_q;
      frame_start_d = 1'b0;
      v_sat_hit     = 1'b0;
      px_valid_d    = de_lvl;
      x_d           = x_q;
      y_d           = y_q;

      if (hs_rise) begin
         h_meas_d     = (h_cnt_q == HMax) ? HMax : h_cnt_q + 11'd1;
         h_cnt_d      = '0;
         line_start_d = 1'b1;
      end else if (h_cnt_q != HMax) begin
         h_cnt_d   = h_cnt_q + 11'd1;
         h_sat_hit = (h_cnt_q == HMax - 11'd1);
      end

      // The line ending on a coincident hsync edge is folded into v_meas via the +1.
      if (vs_rise) begin
         v_meas_d      = (v_cnt_q == VMax) ? VMax : v_cnt_q + 10'd1;
         v_cnt_d       = '0;
         frame_start_d = 1'b1;
      end else if (hs_rise && (v_cnt_q != VMax)) begin
         v_cnt_d   = v_cnt_q + 10'd1;
         v_sat_hit = (v_cnt_q == VMax - 10'd1);
      end

      if (de_lvl) begin
         x_d = de_rise ? 10'd0 : x_q + 10'd1;
      end
      // y doubles as the active-line count checked at frame start.
      if (vs_rise) begin
         y_d = '0;
      end else if (de_fall) begin
         y_d = y_q + 10'd1;
      end
   end

   // Mismatch detection; all failures in one cycle collapse into one err pulse.
   always_comb begin
      run_len   = {1'b0, x_q} + 11'd1;
      act_lines = y_q + {9'd0, de_fall};
      mismatch  = 1'b0;
      if (state_q != StSearch) begin
         if (hs_rise && !skip_h_q && (h_meas_d != HTotal)) mismatch = 1'b1;
         if (de_fall && (run_len != HActive))              mismatch = 1'b1;
         if (vs_rise && ((v_meas_d != VTotal) || (act_lines != VActive))) mismatch = 1'b1;
         if (h_sat_hit || v_sat_hit)                        mismatch = 1'b1;
      end
      err_d     = mismatch;
      err_cnt_d = (mismatch && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   // Lock FSM next state and good-frame bookkeeping.
   always_comb begin
      state_d     = state_q;
      gf_d        = gf_q;
      frame_bad_d = frame_bad_q;
      skip_h_d    = skip_h_q;

      if (vs_rise)       frame_bad_d = 1'b0;
      else if (mismatch) frame_bad_d = 1'b1;

      if (hs_rise) skip_h_d = 1'b0;

      case (state_q)
         StSearch: begin
            if (vs_rise) begin
               state_d  = StTrack;
               gf_d     = '0;
               // The first line measured after acquisition may be partial.
               skip_h_d = 1'b1;
            end
         end
         StTrack: begin
            if (mismatch) begin
               gf_d = '0;
            end else if (vs_rise && !frame_bad_q) begin
               gf_d = gf_q + 8'd1;
               if (gf_q + 8'd1 >= LockFrames) state_d = StLocked;
            end
         end
         StLocked: begin
            if (mismatch) begin
               state_d = StTrack;
               gf_d    = '0;
            end
         end
         default: state_d = StSearch;
      endcase
   end

   // State register for all counters, outputs and the lock FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q       <= '0;
         h_meas_q      <= '0;
         line_start_q  <= 1'b0;
         v_cnt_q       <= '0;
         v_meas_q      <= '0;
         frame_start_q <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         px_valid_q    <= 1'b0;
         skip_h_q      <= 1'b0;
         err_q         <= 1'b0;
         err_cnt_q     <= '0;
         gf_q          <= '0;
         frame_bad_q   <= 1'b0;
         state_q       <= StSearch;
      end else begin
         h_cnt_q       <= h_cnt_d;
         h_meas_q      <= h_meas_d;
         line_start_q  <= line_start_d;
         v_cnt_q       <= v_cnt_d;
         v_meas_q      <= v_meas_d;
         frame_start_q <= frame_start_d;
         x_q           <= x_d;
         y_q           <= y_d;
         px_valid_q    <= px_valid_d;
         skip_h_q      <= skip_h_d;
         err_q         <= err_d;
         err_cnt_q     <= err_cnt_d;
         gf_q          <= gf_d;
         frame_bad_q   <= frame_bad_d;
         state_q       <= state_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign px_valid    = px_valid_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign h_meas      = h_meas_q;
   assign v_meas      = v_meas_q;
   assign locked      = (state_q == StLocked);
   assign err         = err_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_rx_decode.sv
// Scoreboard bench for vga_rx_decode using a shrunken but structurally faithful timing.
module tb_vga_rx_decode;

   localparam int HA     = 16;
   localparam int VA     = 6;
   localparam int HT     = 24;
   localparam int VT     = 10;
   localparam int HS_W   = 3;
   localparam int VS_W   = 2;
   localparam int DE_BEG = 5;
   localparam int VA_BEG = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        hsync = 1'b1;
   logic        vsync = 1'b1;
   logic        de = 1'b0;
   logic [9:0]  x, y, v_meas;
   logic [10:0] h_meas;
   logic [7:0]  err_cnt;
   logic        px_valid, line_start, frame_start, locked, err;

   vga_rx_decode #(
      .H_ACTIVE   (HA),
      .V_ACTIVE   (VA),
      .H_TOTAL    (HT),
      .V_TOTAL    (VT),
      .SYNC_NEG   (1'b1),
      .LOCK_FRAMES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .hsync      (hsync),
      .vsync      (vsync),
      .de         (de),
      .x          (x),
      .y          (y),
      .px_valid   (px_valid),
      .line_start (line_start),
      .frame_start(frame_start),
      .h_meas     (h_meas),
      .v_meas     (v_meas),
      .locked     (locked),
      .err        (err),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ls;
      logic       fs;
      logic       px;
      logic [9:0] x;
      logic [9:0] y;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Event bookkeeping gathered every cycle.
   int          err_seen = 0, err_ls = 0, err_defall = 0, fs_seen = 0, both_seen = 0;
   int          rise_fs_idx = -1;
   logic        rise_with_fs = 1'b0, drop_with_err = 1'b0;
   logic        prev_locked = 1'b0, prev_px = 1'b0;
   logic [10:0] h_at_err = '0;
   int          y_m = 0;

   task automatic drive_cycle(input logic hs_a, input logic vs_a, input logic de_a,
                              input exp_t e);
      exp_t e0;
      hsync = ~hs_a;
      vsync = ~vs_a;
      de    = de_a;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 2) begin
         e0 = exp_q.pop_front();
         checks++;
         if ({line_start, frame_start, px_valid} !== {e0.ls, e0.fs, e0.px}) begin
            errors++;
            $display("FAIL pulses t=%0t ls/fs/px got %b%b%b want %b%b%b", $time,
                     line_start, frame_start, px_valid, e0.ls, e0.fs, e0.px);
         end
         if (e0.px) begin
            checks++;
            if (x !== e0.x || y !== e0.y) begin
               errors++;
               $display("FAIL coord t=%0t got x=%0d y=%0d want x=%0d y=%0d", $time,
                        x, y, e0.x, e0.y);
            end
         end
      end
      if (err === 1'b1) begin
         err_seen++;
         h_at_err = h_meas;
         if (line_start) err_ls++;
         if (prev_px && !px_valid) err_defall++;
      end
      if (frame_start === 1'b1) fs_seen++;
      if (line_start === 1'b1 && frame_start === 1'b1) both_seen++;
      if (locked && !prev_locked) begin
         rise_fs_idx  = fs_seen;
         rise_with_fs = frame_start;
      end
      if (!locked && prev_locked) drop_with_err = err;
      prev_locked = locked;
      prev_px     = px_valid;
   endtask

   task automatic pulse_reset(input logic hs_a, input logic vs_a, input logic de_a);
      hsync = ~hs_a;
      vsync = ~vs_a;
      de    = de_a;
      exp_q.delete();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({x, y, px_valid} !== '0) begin
         errors++;
         $display("FAIL mid_reset_pixel got x=%0d y=%0d px=%b want 0", x, y, px_valid);
      end
      checks++;
      if ({line_start, frame_start, h_meas, v_meas} !== '0) begin
         errors++;
         $display("FAIL mid_reset_meas got ls=%b fs=%b h=%0d v=%0d want 0",
                  line_start, frame_start, h_meas, v_meas);
      end
      checks++;
      if ({locked, err, err_cnt} !== '0) begin
         errors++;
         $display("FAIL mid_reset_lock got locked=%b err=%b cnt=%0d want 0",
                  locked, err, err_cnt);
      end
      rst         = 1'b0;
      prev_locked = 1'b0;
      prev_px     = 1'b0;
      y_m         = 0;
   endtask

   task automatic run_line(input int vc, input int len, input int de_len, input int rst_hc);
      exp_t e;
      logic hs_a, vs_a, de_a;
      bit   had_de = 0;
      for (int hc = 0; hc < len; hc++) begin
         hs_a = (hc < HS_W);
         vs_a = (vc < VS_W);
         de_a = (vc >= VA_BEG) && (vc < VA_BEG + VA) && (hc >= DE_BEG) && (hc < DE_BEG + de_len);
         if (vs_a && vc == 0 && hc == 0) y_m = 0;
         e.ls = hs_a && (hc == 0);
         e.fs = vs_a && (vc == 0) && (hc == 0);
         e.px = de_a;
         e.x  = 10'(hc - DE_BEG);
         e.y  = 10'(y_m);
         if (hc == rst_hc) begin
            pulse_reset(hs_a, vs_a, de_a);
            had_de = 0;
         end else begin
            drive_cycle(hs_a, vs_a, de_a, e);
            if (de_a) had_de = 1;
         end
      end
      if (had_de) y_m++;
   endtask

   task automatic run_frame(input int long_vc, input int short_vc, input int rst_vc);
      for (int vc = 0; vc < VT; vc++) begin
         run_line(vc, (vc == long_vc) ? HT + 1 : HT, (vc == short_vc) ? HA - 1 : HA,
                  (vc == rst_vc) ? HA + DE_BEG + 1 : -1);
      end
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({x, y, px_valid, line_start, frame_start} !== '0) begin
         errors++;
         $display("FAIL reset_pixel got x=%0d y=%0d px=%b ls=%b fs=%b want 0",
                  x, y, px_valid, line_start, frame_start);
      end
      checks++;
      if ({h_meas, v_meas} !== '0) begin
         errors++;
         $display("FAIL reset_meas got h=%0d v=%0d want 0", h_meas, v_meas);
      end
      checks++;
      if ({locked, err, err_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_lock got locked=%b err=%b cnt=%0d want 0", locked, err, err_cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_clean;
      run_frame(-1, -1, -1);
      run_frame(-1, -1, -1);
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL clean_early_lock got %b want 0", locked);
      end
      run_frame(-1, -1, -1);
      checks++;
      if (locked !== 1'b1 || rise_fs_idx != 3 || rise_with_fs !== 1'b1) begin
         errors++;
         $display("FAIL clean_lock got locked=%b at_fs=%0d with_fs=%b want 1 3 1",
                  locked, rise_fs_idx, rise_with_fs);
      end
      checks++;
      if (err_cnt !== 8'd0 || err_seen != 0) begin
         errors++;
         $display("FAIL clean_err got cnt=%0d pulses=%0d want 0 0", err_cnt, err_seen);
      end
      checks++;
      if (h_meas !== 11'(HT) || v_meas !== 10'(VT)) begin
         errors++;
         $display("FAIL clean_meas got h=%0d v=%0d want %0d %0d", h_meas, v_meas, HT, VT);
      end
   endtask

   task automatic test_long_line;
      int e0 = err_seen;
      int l0 = err_ls;
      run_frame(4, -1, -1);
      checks++;
      if (err_seen - e0 != 1 || err_ls - l0 != 1 || h_at_err !== 11'(HT + 1)) begin
         errors++;
         $display("FAIL long_line_err got pulses=%0d at_ls=%0d h=%0d want 1 1 %0d",
                  err_seen - e0, err_ls - l0, h_at_err, HT + 1);
      end
      checks++;
      if (err_cnt !== 8'd1 || locked !== 1'b0 || drop_with_err !== 1'b1) begin
         errors++;
         $display("FAIL long_line_lock got cnt=%0d locked=%b drop_on_err=%b want 1 0 1",
                  err_cnt, locked, drop_with_err);
      end
      run_frame(-1, -1, -1);
      run_frame(-1, -1, -1);
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL long_line_relock_early got %b want 0", locked);
      end
      run_frame(-1, -1, -1);
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL long_line_relock got %b want 1", locked);
      end
   endtask

   task automatic test_short_run;
      int e0 = err_seen;
      int d0 = err_defall;
      run_frame(-1, 4, -1);
      checks++;
      if (err_seen - e0 != 1 || err_defall - d0 != 1) begin
         errors++;
         $display("FAIL short_run_err got pulses=%0d at_de_fall=%0d want 1 1",
                  err_seen - e0, err_defall - d0);
      end
      checks++;
      if (err_cnt !== 8'd2 || locked !== 1'b0) begin
         errors++;
         $display("FAIL short_run_lock got cnt=%0d locked=%b want 2 0", err_cnt, locked);
      end
      run_frame(-1, -1, -1);
      run_frame(-1, -1, -1);
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL short_run_gf got locked=%b want 0", locked);
      end
      run_frame(-1, -1, -1);
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL short_run_relock got %b want 1", locked);
      end
   endtask

   task automatic test_hsync_stuck;
      exp_t idle;
      int   e0 = err_seen;
      int   c0 = int'(err_cnt);
      idle = '{ls: 1'b0, fs: 1'b0, px: 1'b0, x: '0, y: '0};
      repeat (2100) drive_cycle(1'b0, 1'b0, 1'b0, idle);
      checks++;
      if (err_seen - e0 != 1 || int'(err_cnt) != c0 + 1) begin
         errors++;
         $display("FAIL stuck_sat got pulses=%0d cnt=%0d want 1 %0d",
                  err_seen - e0, err_cnt, c0 + 1);
      end
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL stuck_lock got %b want 0", locked);
      end
      run_frame(-1, -1, -1);
      checks++;
      if (h_at_err !== 11'h7FF || h_meas !== 11'(HT)) begin
         errors++;
         $display("FAIL stuck_resume got h_at_err=%0d h=%0d want 2047 %0d",
                  h_at_err, h_meas, HT);
      end
      run_frame(-1, -1, -1);
      run_frame(-1, -1, -1);
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL stuck_relock got %b want 1", locked);
      end
   endtask

   task automatic test_simultaneous;
      int b0 = both_seen;
      int e0 = err_seen;
      run_frame(-1, -1, -1);
      checks++;
      if (both_seen - b0 != 1 || v_meas !== 10'(VT) || err_seen != e0) begin
         errors++;
         $display("FAIL simul_edges got both=%0d v=%0d errs=%0d want 1 %0d 0",
                  both_seen - b0, v_meas, err_seen - e0, VT);
      end
   endtask

   task automatic test_reset_mid;
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_pre got locked=%b want 1", locked);
      end
      run_frame(-1, -1, 5);
      run_frame(-1, -1, -1);
      run_frame(-1, -1, -1);
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_early got locked=%b want 0", locked);
      end
      run_frame(-1, -1, -1);
      checks++;
      if (locked !== 1'b1 || err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid_relock got locked=%b cnt=%0d want 1 0", locked, err_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_long_line();
      test_short_run();
      test_hsync_stuck();
      test_simultaneous();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
